gcd_sched: RTL and testbench
============================

# gcd_sched

Round-robin scheduler sharing a single binary GCD engine among `NREQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The scheduler grants one requester, runs the GCD engine on that requester's operands, and returns the result with the requester's index on one response channel. It replaces per-requester GCD instances and the earlier scheme that recalculated whenever the inputs changed: the operands are captured once at acceptance, and later input changes are ignored.

## Interface
- `WIDTH`, 7: operand and result width.
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, `$clog2(NREQ)`: response index width (derived; do not override).
- `clk`  in  1  single clock, rising edge.
- `rst_`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit high.
- `req_a`  in  NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- `req_b`  in  NREQ*WIDTH  operand B; same packing as `req_a`.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  IDW  index of the requester the result belongs to.
- `rsp_gcd`  out  WIDTH  gcd(A,B).
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, RUN, RESP.
- **IDLE:**
  - `g` is the first index i, searching from `ptr` upward with wrap, for which `req_valid[i]` is high.
  - `req_ready[g]` is driven combinationally high. No other `req_ready` bit is high.
  - On the handshake edge: the block captures `req_a[g]` and `req_b[g]` into the core, sets `ptr <= g+1` (wrapping at `NREQ`), stores `g` as the id, and moves to RUN.
  - With no valid request, the block stays in IDLE and `req_ready` is 0.
- **RUN:**
  - The core performs one step per clock.
  - All `req_ready` bits are 0.
  - When core `done` is high, the block registers the result into `rsp_gcd`, `rsp_id <= id`, `rsp_valid <= 1`, and moves to RESP.
- **RESP:**
  - `rsp_valid`, `rsp_id` and `rsp_gcd` are held stable until `rsp_ready` is high.
  - On `rsp_valid && rsp_ready`, the block clears `rsp_valid` and returns to IDLE.
  - While `rsp_ready` stays low, no new request is accepted.
- **Core step rules** (registers `a`, `b`, and shift count `k`, cleared at load). The first matching rule applies:
  - `a==0`: done, result `b<<k`.
  - `b==0`: done, result `a<<k`.
  - `a==b`: done, result `a<<k`.
  - Both even: shift `a` and `b` right by one; `k++`.
  - `a` even only: `a>>=1`.
  - `b` even only: `b>>=1`.
  - Both odd: `a <= |a-b|>>1`, `b <= min(a,b)`.
- **Widths:**
  - The result never exceeds max(A,B), so `WIDTH` bits suffice.
  - `k` is `$clog2(WIDTH+1)` bits.
  - gcd(0,0)=0 and gcd(x,0)=x.
- **Protocol rules:**
  - A requester holds `req_valid` and its operands until it sees `req_ready`.
  - Operand changes after acceptance have no effect.
  - Operands are unsigned.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_gcd`=0, `busy`=0, `ptr`=0, state IDLE, core registers 0.
- Assertion of `rst_` mid-operation discards the in-flight job and any held response immediately. That job produces no response.
- **Latency:** `rsp_valid` rises S edges after the acceptance edge. S is the number of core steps including the terminating step; S ≥ 1, and S = 1 for a==b or for a zero operand.
- **Worst-case S:** ≤ 2*WIDTH+1.
- **Throughput:** back-to-back jobs are possible. The response handshake edge returns the block to IDLE, and the next accept can happen on the following edge, so the minimum job period is S+2 cycles.
- **Simultaneous requests:** arbitration is round-robin. After requester i is served, it has the lowest priority.

## Structure
- Shared package `gcd_pkg` holds:
  - FSM state encodings (IDLE, RUN, RESP).
  - The `WIDTH` default.
  - The worst-case step bound constant `GCD_MAX_STEPS(w) = 2*w+1`, which the bench uses for its timeout.
- Sub-module `gcd_core`:
  - Inputs: `clk`, `rst_`, `start`, `a_in`, `b_in`.
  - Outputs: combinational `done` and `result`, valid in any step where a terminal rule matches.
  - `start` loads the operands and clears `k`.
- Round-robin selection is a function inside `gcd_sched`. It needs no separate module.

## Test plan
- **Single job:** requester 0 with A=12, B=18, `rsp_ready`=1 → `rsp_gcd`=6, `rsp_id`=0, `rsp_valid` high 4 edges after acceptance, for one cycle.
- **Zero operands:** (0,0) → 0; (0,35) → 35; (42,42) → 42. Each with S=1.
- **Round-robin fairness:** all four requesters valid continuously, `ptr`=0, operands (i+1)*6 and 4 → responses 2,4,2,4 with ids 0,1,2,3, then 0 again.
- **Response backpressure:** `rsp_ready` held low for 10 cycles → response held stable, `req_ready` stays 0, no second accept. Releasing `rsp_ready` → the next job is accepted on the following edge.
- **Reset mid-run:** A=96, B=64, `rst_` low 2 cycles after accept → all outputs at reset values asynchronously, no response after reset release. A new request for 96/64 then returns 32.
- **Random soak:** random operand pairs with random `rsp_ready` → every result matches the reference gcd, every job completes within `GCD_MAX_STEPS`+2 cycles, and the response order matches the acceptance order.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and constants for the shared GCD scheduler and its engine.
package gcd_pkg;

    localparam int GCD_WIDTH = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Upper bound on engine steps for w-bit operands, terminating step included.
    function automatic int GCD_MAX_STEPS(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/gcd_core.sv
// Binary (Stein) GCD engine, one reduction step per clock; start loads operands.
// Latency: done/result are combinational and valid as soon as a terminal rule matches.
// Backpressure: none; the engine freezes in its terminal state until the next start.
module gcd_core
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int KW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic [KW-1:0]    k;

    always_comb begin
        done   = 1'b1;
        result = '0;
        if (a == '0) begin
            result = b << k;
        end else if (b == '0 || a == b) begin
            result = a << k;
        end else begin
            done = 1'b0;
        end
    end

    assign diff = (a > b) ? a - b : b - a;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            a <= '0;
            b <= '0;
            k <= '0;
        end else if (start) begin
            a <= a_in;
            b <= b_in;
            k <= '0;
        end else if (!done) begin
            case ({a[0], b[0]})
                2'b00: begin
                    a <= a >> 1;
                    b <= b >> 1;
                    k <= k + KW'(1);
                end
                2'b01:   a <= a >> 1;
                2'b10:   b <= b >> 1;
                default: begin
                    // Both odd: the difference is even, so halving it loses nothing.
                    a <= diff >> 1;
                    b <= (a < b) ? a : b;
                end
            endcase
        end
    end

endmodule

// File: rtl/gcd_sched.sv
// Round-robin scheduler sharing one gcd_core among NREQ requesters.
// Latency: rsp_valid rises S edges after the accept edge (S = engine steps, >= 1).
// Backpressure: a held response blocks all new accepts until rsp_ready.
module gcd_sched
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_gcd,
    output logic                  busy
);

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   id;
    logic [IDW-1:0]   grant;
    logic             accept;
    logic             core_done;
    logic [WIDTH-1:0] core_result;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // First valid index at or after p, wrapping; lower offsets overwrite higher ones.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                               input logic [IDW-1:0]  p);
        logic [IDW-1:0] sel;
        int             idx;
        sel = p;
        for (int n = NREQ - 1; n >= 0; n--) begin
            idx = (int'(p) + n) % NREQ;
            if (v[idx]) sel = IDW'(idx);
        end
        return sel;
    endfunction

    assign grant = rr_pick(req_valid, ptr);
    assign sel_a = req_a[int'(grant) * WIDTH +: WIDTH];
    assign sel_b = req_b[int'(grant) * WIDTH +: WIDTH];
    assign busy  = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                // Gate with reset so nothing looks accepted while the block is held.
                if (rst_ && |req_valid) begin
                    req_ready[grant] = 1'b1;
                    accept           = 1'b1;
                    state_nxt        = ST_RUN;
                end
            end
            ST_RUN:  if (core_done) state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ptr       <= '0;
            id        <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_gcd   <= '0;
        end else begin
            if (accept) begin
                ptr <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
                id  <= grant;
            end
            if (state == ST_RUN && core_done) begin
                rsp_valid <= 1'b1;
                rsp_id    <= id;
                rsp_gcd   <= core_result;
            end else if (state == ST_RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    gcd_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .rst_   (rst_),
        .start  (accept),
        .a_in   (sel_a),
        .b_in   (sel_b),
        .done   (core_done),
        .result (core_result)
    );

endmodule

// File: tb/tb_gcd_sched.sv
// Scoreboard bench for gcd_sched: expectations queued at accept, checked at response.
module tb_gcd_sched;
    import gcd_pkg::*;

    localparam int W   = 7;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_ = 1'b1;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_gcd;
    logic           busy;

    logic         vld  [N];
    logic [W-1:0] op_a [N];
    logic [W-1:0] op_b [N];

    typedef struct {
        int id;
        int g;
    } exp_t;

    exp_t exp_q[$];
    int   acc_ids[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   acc_edge = 0;
    int   cons_edge = 0;
    int   n_acc = 0;
    int   last_lat = 0;
    int   run_len = 0;
    int   last_len = 0;
    logic prev_vld = 1'b0;
    bit   soak_done = 1'b0;

    gcd_sched #(.WIDTH(W), .NREQ(N)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_gcd   (rsp_gcd),
        .busy      (busy)
    );

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign req_valid[gi]         = vld[gi];
        assign req_a[gi*W +: W]      = op_a[gi];
        assign req_b[gi*W +: W]      = op_b[gi];
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int ref_gcd(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Scoreboard: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        if (!rst_) begin
            run_len  = 0;
            prev_vld = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_q.push_back('{id: i, g: ref_gcd(int'(op_a[i]), int'(op_b[i]))});
                    acc_ids.push_back(i);
                    acc_edge = cyc + 1;
                    n_acc++;
                end
            end
            if (rsp_valid && !prev_vld) begin
                last_lat = cyc - acc_edge;
                chk("lat_bound", 32'(last_lat >= 1 && last_lat <= GCD_MAX_STEPS(W)), 1);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_id", 32'(rsp_id), e.id);
                    chk("rsp_gcd", 32'(rsp_gcd), e.g);
                end
                cons_edge = cyc + 1;
            end
            if (rsp_valid) begin
                run_len++;
            end else if (run_len != 0) begin
                last_len = run_len;
                run_len  = 0;
            end
            prev_vld = rsp_valid;
        end
    end

    task automatic wait_accept(input int i);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(req_ready[i] && rst_) && t < 3000);
        if (t >= 3000) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        vld[i]  = 1'b0;
        op_a[i] = W'($urandom);
        op_b[i] = W'($urandom);
    endtask

    task automatic submit(input int i, input int a, input int b);
        @(posedge clk);
        #1;
        op_a[i] = W'(a);
        op_b[i] = W'(b);
        vld[i]  = 1'b1;
        wait_accept(i);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("drain_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst_ = 1'b0;
        exp_q.delete();
        acc_ids.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_ = 1'b1;
    endtask

    task automatic soak_req(input int i);
        repeat (15) begin
            @(posedge clk);
            #1;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            case ($urandom_range(0, 5))
                0:       begin op_a[i] = '0; op_b[i] = W'($urandom); end
                1:       begin op_a[i] = W'($urandom); op_b[i] = op_a[i]; end
                default: begin op_a[i] = W'($urandom); op_b[i] = W'($urandom); end
            endcase
            vld[i] = 1'b1;
            wait_accept(i);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            vld[i]  = 1'b0;
            op_a[i] = '0;
            op_b[i] = '0;
        end
        #1;
        rst_ = 1'b0;
        for (int i = 0; i < N; i++) vld[i] = 1'b1;
        #3;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_gcd", 32'(rsp_gcd), 0);
        chk("rst_busy", 32'(busy), 0);
        for (int i = 0; i < N; i++) vld[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_ = 1'b1;

        // Single job: 12/18 -> 6 after four steps, one-cycle response.
        rsp_ready = 1'b1;
        submit(0, 12, 18);
        wait_drain();
        chk("single_lat", last_lat, 4);
        chk("single_vld_len", last_len, 1);

        // Terminal-on-first-step cases.
        submit(1, 0, 0);
        wait_drain();
        chk("zero_zero_lat", last_lat, 1);
        submit(2, 0, 35);
        wait_drain();
        chk("zero_35_lat", last_lat, 1);
        submit(3, 42, 42);
        wait_drain();
        chk("equal_lat", last_lat, 1);
        submit(1, 100, 0);
        wait_drain();
        chk("x_zero_lat", last_lat, 1);

        // Round-robin fairness from ptr=0 with everyone requesting.
        reset_dut();
        begin
            int t = 0;
            int base;
            base = n_acc;
            for (int i = 0; i < N; i++) begin
                op_a[i] = W'((i + 1) * 6);
                op_b[i] = W'(4);
                vld[i]  = 1'b1;
            end
            while (n_acc < base + 5 && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (t >= 500) chk("rr_timeout", 0, 1);
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) vld[i] = 1'b0;
            wait_drain();
            chk("rr_count", acc_ids.size(), 5);
            for (int j = 0; j < 5 && j < acc_ids.size(); j++)
                chk($sformatf("rr_order%0d", j), acc_ids[j], j % N);
        end

        // Backpressure: held response blocks requester 2.
        begin
            int t = 0;
            int acc0;
            rsp_ready = 1'b0;
            @(posedge clk);
            #1;
            op_a[1] = W'(30); op_b[1] = W'(12); vld[1] = 1'b1;
            op_a[2] = W'(21); op_b[2] = W'(14); vld[2] = 1'b1;
            wait_accept(1);
            while (!rsp_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) chk("bp_rsp_timeout", 0, 1);
            acc0 = n_acc;
            repeat (10) begin
                @(negedge clk);
                chk("bp_valid", 32'(rsp_valid), 1);
                chk("bp_id", 32'(rsp_id), 1);
                chk("bp_gcd", 32'(rsp_gcd), 6);
                chk("bp_req_ready", 32'(req_ready), 0);
                chk("bp_no_accept", n_acc, acc0);
            end
            @(posedge clk);
            #1;
            rsp_ready = 1'b1;
            wait_accept(2);
            chk("bp_next_accept_gap", acc_edge - cons_edge, 1);
            wait_drain();
        end

        // Reset mid-run discards the job.
        begin
            int highs = 0;
            @(posedge clk);
            #1;
            op_a[0] = W'(96); op_b[0] = W'(64); vld[0] = 1'b1;
            wait_accept(0);
            @(posedge clk);
            #1;
            rst_ = 1'b0;
            exp_q.delete();
            #1;
            chk("mid_rst_req_ready", 32'(req_ready), 0);
            chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
            chk("mid_rst_rsp_id", 32'(rsp_id), 0);
            chk("mid_rst_rsp_gcd", 32'(rsp_gcd), 0);
            chk("mid_rst_busy", 32'(busy), 0);
            repeat (2) @(posedge clk);
            #1;
            rst_ = 1'b1;
            repeat (20) begin
                @(negedge clk);
                if (rsp_valid) highs++;
            end
            chk("mid_rst_no_rsp", highs, 0);
            submit(0, 96, 64);
            wait_drain();
            chk("after_rst_lat", last_lat, 8);
        end

        // Random soak with all requesters and random response backpressure.
        fork
            begin
                fork
                    soak_req(0);
                    soak_req(1);
                    soak_req(2);
                    soak_req(3);
                join
                soak_done = 1'b1;
            end
            begin
                while (!soak_done) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
                rsp_ready = 1'b1;
            end
        join
        wait_drain();
        chk("soak_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
